regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the 8-bit CPU datapath. It provides one write port and NRD independent synchronous read ports over a 2^AW-entry array, with write-to-read bypass, optional hardwired-zero register 0, and a hardware clear sequencer. The sequencer zeroes every entry after reset or on request. It sits between the decode stage (read addresses) and writeback (write port), and supersedes the fixed 8-bit, 64-entry, two-read-port register file.

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 6, address width; depth = 2^AW entries
- NRD, 2, number of read ports (1..4)
- ZERO_R0, 0, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  pulse: restart clear sweep (honoured only when ready=1)
- wr  in  1  write enable
- ad  in  AW  write address
- rd  in  DW  write data
- raddr  in  NRD*AW  packed read addresses; port k = raddr[k*AW +: AW]
- rdata  out  NRD*DW  packed registered read data; port k = rdata[k*DW +: DW]
- ready  out  1  high when array is usable (state IDLE)

## Operation
- Storage: 2^AW x DW array, not reset directly; contents defined only through the clear sweep.
- FSM states:
  - CLEAR: counter cnt (AW+1 bits) writes 0 to entry cnt[AW-1:0] each cycle. On cnt = 2^AW-1, go to IDLE next cycle.
  - IDLE: normal access. clr=1 loads cnt=0 and goes to CLEAR next cycle.
- Reset: state=CLEAR, cnt=0, ready=0, rdata=0, all bits.
- Write (IDLE only): if wr=1, array[ad] <= rd at the clock edge. Suppressed when ZERO_R0=1 and ad=0. wr in CLEAR is dropped silently (no stall, no queue).
- Read (each port k independently): rdata_k <= array[raddr_k] at the clock edge.
  - Bypass: if wr=1 and ad==raddr_k in the same cycle (IDLE), rdata_k <= rd (write-first), except when ZERO_R0=1 and address is 0.
  - ZERO_R0=1 and raddr_k=0: rdata_k <= 0.
  - In CLEAR: rdata_k <= 0 for all ports regardless of address.
- clr and wr in the same IDLE cycle: the write is performed, then the sweep starts and overwrites it.
- clr in CLEAR: ignored; the sweep is not restarted.
- rst_n asserted mid-sweep or mid-write: immediate return to reset state; a write on the same edge is not guaranteed.
- Multiple read ports on the same address return identical data.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N, held until next edge).
- Write visible to a non-bypassed read issued the cycle after the write edge; bypassed read in the write cycle itself.
- Clear sweep: 2^AW cycles. ready rises on the edge ending the last clear write. With AW=6: ready=1 exactly 64 rising edges after rst_n deasserts.
- After clr in IDLE: ready=0 from next edge for 2^AW cycles, then 1.
- ready is registered, glitch-free; no combinational path from any input to rdata or ready.

## Test plan
- Reset release, AW=6: count edges until ready=1 -> exactly 64; rdata=0 throughout; afterwards read all 64 entries -> all 0.
- IDLE: write 0xA5 to addr 5, next cycle read port 0 addr 5 and port 1 addr 5 -> both 0xA5 one cycle later.
- Same-cycle bypass: wr=1, ad=9, rd=0x3C, raddr0=9, raddr1=10 (holding 0x11) -> rdata0=0x3C, rdata1=0x11 after that edge.
- ZERO_R0=1: write 0xFF to addr 0 with raddr0=0 -> rdata0=0 in bypass cycle and on subsequent reads; ZERO_R0=0 -> 0xFF.
- clr with wr to addr 3 in same cycle, then wr to addr 4 during sweep -> ready low 64 cycles; afterwards addr 3 and addr 4 read 0.
- rst_n pulsed low at sweep cycle 20 -> outputs return to reset values immediately; ready rises 64 edges after the second release.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, optional zero r0 and a clear sweep
// Ports: clk/rst_n (async active-low); clr restarts the sweep when ready;
//        wr/ad/rd write port; raddr/rdata NRD packed read ports (1-cycle latency);
//        ready high once the array has been swept and is usable.
module regfile_mp #(
    parameter int DW      = 8,
    parameter int AW      = 6,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [AW-1:0]     ad,
    input  logic [DW-1:0]     rd,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic              ready
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t              r_state;
    logic [AW:0]         r_cnt;
    logic [DW-1:0]       r_mem [2**AW];
    logic                w_we;
    logic [NRD*DW-1:0]   w_rdata;
    assign w_we = r_state == IDLE && wr && !(ZERO_R0 != 0 && ad == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
        end else begin
            rdata <= w_rdata;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == {1'b0, {AW{1'b1}}}) begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
            end else if (clr) begin
                r_state <= CLEAR;
                r_cnt   <= '0;
                ready   <= 1'b0;
            end
        end
    end
    // The array has no reset; its contents are defined solely by the sweep.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR)
            r_mem[r_cnt[AW-1:0]] <= '0;
        else if (w_we)
            r_mem[ad] <= rd;
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_a;
        assign w_a = raddr[k*AW +: AW];
        // w_we already excludes the hardwired-zero address, so bypass never leaks into r0.
        assign w_rdata[k*DW +: DW] = (r_state == CLEAR || (ZERO_R0 != 0 && w_a == '0)) ? '0 :
                                     (w_we && ad == w_a) ? rd : r_mem[w_a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed check of regfile_mp against a behavioural model
module tb_regfile_mp;
    localparam int DW = 8, AW = 6, NRD = 2, N = 64;
    logic              clk = 1'b0, rst_n = 1'b1, clr = 1'b0, wr = 1'b0;
    logic [AW-1:0]     ad = '0;
    logic [DW-1:0]     rd = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*DW-1:0] rdata, rdata_z;
    logic              ready, ready_z;
    int                n_chk = 0, n_fail = 0, clr_left = 0, cnt = 0;
    logic [DW-1:0]     m [N];

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .ad(ad), .rd(rd),
        .raddr(raddr), .rdata(rdata), .ready(ready));
    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .ad(ad), .rd(rd),
        .raddr(raddr), .rdata(rdata_z), .ready(ready_z));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: while sweeping, every read is 0 and writes vanish, so the whole
    // array can be treated as zero from the moment the sweep starts.
    task automatic step();
        logic [NRD*DW-1:0] e, ez;
        logic [AW-1:0]     a;
        logic [DW-1:0]     v;
        for (int k = 0; k < NRD; k++) begin
            a = raddr[k*AW +: AW];
            v = (clr_left > 0) ? '0 : (wr && ad == a) ? rd : m[a];
            e[k*DW +: DW]  = v;
            ez[k*DW +: DW] = (a == 0) ? '0 : v;
        end
        if (clr_left > 0) clr_left--;
        else begin
            if (wr) m[ad] = rd;
            if (clr) begin
                for (int i = 0; i < N; i++) m[i] = '0;
                clr_left = N;
            end
        end
        @(posedge clk);
        #1;
        chk("rdata", rdata, e);
        chk("rdata_z", rdata_z, ez);
        chk("ready", ready, clr_left == 0);
        chk("ready_z", ready_z, clr_left == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rdata_z", rdata_z, 0);
        chk("rst_ready", ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m[i] = '0;
        clr_left = N;
    endtask

    task automatic rnd_in(input bit allow_clr, input int amax);
        wr    = 1'($urandom_range(0, 1));
        ad    = AW'($urandom_range(0, amax));
        rd    = DW'($urandom_range(0, 255));
        raddr = {AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax))};
        clr   = allow_clr ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic wait_ready(input string name);
        cnt = 0;
        while (!ready && cnt < 200) begin
            rnd_in(1, N - 1);
            step();
            cnt++;
        end
        clr = 1'b0;
        chk(name, cnt, 64);
    endtask

    initial begin
        #2;
        do_reset();
        wait_ready("ready_edges_reset");
        wr = 1'b0;
        for (int i = 0; i < N; i += 2) begin
            raddr = {AW'(i + 1), AW'(i)};
            step();
            chk("post_clear_zero", rdata, 0);
        end
        wr = 1'b1; ad = 5; rd = 8'hA5; raddr = {6'd7, 6'd8};
        step();
        wr = 1'b0; raddr = {6'd5, 6'd5};
        step();
        chk("read_a5", rdata, 16'hA5A5);
        wr = 1'b1; ad = 10; rd = 8'h11;
        step();
        ad = 9; rd = 8'h3C; raddr = {6'd10, 6'd9};
        step();
        chk("bypass", rdata, 16'h113C);
        ad = 0; rd = 8'hFF; raddr = {6'd0, 6'd0};
        step();
        chk("r0_bypass_z", rdata_z, 0);
        chk("r0_bypass", rdata[7:0], 8'hFF);
        wr = 1'b0;
        step();
        chk("r0_read_z", rdata_z, 0);
        chk("r0_read", rdata, 16'hFFFF);
        for (int i = 0; i < 400; i++) begin
            rnd_in(0, 15);
            step();
        end
        wr = 1'b1; ad = 3; rd = 8'h77; clr = 1'b1; raddr = {6'd3, 6'd3};
        step();
        clr = 1'b0;
        chk("clr_ready_low", ready, 0);
        ad = 4; rd = 8'h44; raddr = {6'd4, 6'd4};
        step();
        cnt = 1;
        wr = 1'b0;
        while (!ready && cnt < 200) begin
            rnd_in(1, N - 1);
            step();
            cnt++;
        end
        clr = 1'b0;
        chk("ready_edges_clr", cnt, 64);
        wr = 1'b0; raddr = {6'd4, 6'd3};
        step();
        chk("clr_wiped", rdata, 0);
        wr = 1'b1; ad = 20; rd = 8'h5A;
        step();
        wr = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rnd_in(0, N - 1);
            step();
        end
        do_reset();
        wait_ready("ready_edges_rerst");
        wr = 1'b0; raddr = {6'd20, 6'd20};
        step();
        chk("rerst_zero", rdata, 0);
        for (int i = 0; i < 300; i++) begin
            rnd_in(i % 97 == 0, 15);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
